// File: rtl/mac_operand_feeder_pkg.sv
// rtl/mac_operand_feeder_pkg.sv - shared types for the MAC operand feeder
package mac_operand_feeder_pkg;

  localparam int INFO_W = 3;
  localparam int ELEM_W = 8;

  typedef logic [ELEM_W-1:0] elem_t;

  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } info_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/mac_operand_feeder_skew_delay.sv
// rtl/mac_operand_feeder_skew_delay.sv - N-stage clear-on-reset register line
// N=0 degenerates to a plain wire so the chain-tail column needs no special case.
module mac_operand_feeder_skew_delay #(
  parameter int W = 1,
  parameter int N = 0
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  if (N == 0) begin : g_wire
    logic w_unused;
    assign w_unused = i_clk ^ i_reset;
    assign o_q      = i_d;
  end else begin : g_regs
    logic [W-1:0] r_pipe [N];

    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        for (int k = 0; k < N; k++) r_pipe[k] <= '0;
      end else begin
        r_pipe[0] <= i_d;
        for (int k = 1; k < N; k++) r_pipe[k] <= r_pipe[k-1];
      end
    end

    assign o_q = r_pipe[N-1];
  end

endmodule

// File: rtl/mac_operand_feeder.sv
// rtl/mac_operand_feeder.sv - skews A row-slices per column group for the MAC array
// Optional MAC_FEEDER_DRAIN_GAP_EN: DRAIN state holds off input SZJ-1 cycles after each group.
module mac_operand_feeder
  import mac_operand_feeder_pkg::*;
#(
  parameter  int SZI   = 4,
  parameter  int SZJ   = 4,
  parameter  int DEPTH = 4,
  parameter  int AW    = 8,
  parameter  int KW    = 16,
  localparam int DW    = SZJ * DEPTH * AW
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [SZI*DW-1:0] i_data,
  input  logic              i_valid,
  input  logic              i_last,
  output logic              o_ready,
  output logic [SZI*DW-1:0] o_amat,
  output logic [INFO_W-1:0] o_amatinfo,
  output logic              o_group_done,
  output logic [KW-1:0]     o_beat_count,
  output logic              o_busy
);

  localparam int CBW = DEPTH * AW;

  state_t            r_state;
  logic [KW-1:0]     r_beat_count;
  logic [SZI*DW-1:0] r_stage0;
  info_t             r_info;
  logic [SZJ-1:0]    r_vchain;
  logic              w_accept;

  function automatic logic [KW-1:0] sat_inc(input logic [KW-1:0] v);
    return (v == {KW{1'b1}}) ? v : v + KW'(1);
  endfunction

`ifdef MAC_FEEDER_DRAIN_GAP_EN
  localparam int CW = $clog2(SZJ);
  logic          r_ready;
  logic [CW-1:0] r_drain_cnt;
  assign o_ready = r_ready;
`else
  assign o_ready = 1'b1;
`endif

  assign w_accept = i_valid && o_ready;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state      <= IDLE;
      r_beat_count <= '0;
`ifdef MAC_FEEDER_DRAIN_GAP_EN
      r_ready      <= 1'b1;
      r_drain_cnt  <= '0;
`endif
    end else begin
      case (r_state)
        IDLE, RUN: begin
          if (w_accept) begin
            r_beat_count <= (r_state == IDLE) ? KW'(1) : sat_inc(r_beat_count);
            if (i_last) begin
`ifdef MAC_FEEDER_DRAIN_GAP_EN
              r_state     <= DRAIN;
              r_ready     <= 1'b0;
              r_drain_cnt <= CW'(SZJ - 2);
`else
              r_state     <= IDLE;
`endif
            end else begin
              r_state <= RUN;
            end
          end else if (r_state == IDLE) begin
            r_beat_count <= '0;
          end
        end
`ifdef MAC_FEEDER_DRAIN_GAP_EN
        DRAIN: begin
          r_beat_count <= '0;
          if (r_drain_cnt == '0) begin
            r_state <= IDLE;
            r_ready <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt - CW'(1);
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end

  // Idle cycles load zeros so a bubble adds nothing to any chain sum.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_stage0 <= '0;
      r_info   <= '0;
      r_vchain <= '0;
    end else begin
      r_stage0     <= w_accept ? i_data : '0;
      r_info.valid <= w_accept;
      r_info.first <= w_accept && (r_state == IDLE);
      r_info.last  <= w_accept && i_last;
      r_vchain     <= {r_vchain[SZJ-2:0], w_accept};
    end
  end

  for (genvar j = 0; j < SZJ; j++) begin : g_col
    logic [SZI*CBW-1:0] w_col_in;
    logic [SZI*CBW-1:0] w_col_out;

    for (genvar i = 0; i < SZI; i++) begin : g_row
      assign w_col_in[i*CBW +: CBW]       = r_stage0[i*DW + j*CBW +: CBW];
      assign o_amat[i*DW + j*CBW +: CBW]  = w_col_out[i*CBW +: CBW];
    end

    mac_operand_feeder_skew_delay #(
      .W (SZI * CBW),
      .N (SZJ - 1 - j)
    ) u_skew (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_d     (w_col_in),
      .o_q     (w_col_out)
    );
  end

  // The last flag rides alongside column 0 so overlapping groups each get a pulse.
  mac_operand_feeder_skew_delay #(
    .W (1),
    .N (SZJ - 1)
  ) u_last_chain (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_d     (r_info.last),
    .o_q     (o_group_done)
  );

  assign o_amatinfo   = r_info;
  assign o_beat_count = r_beat_count;
  assign o_busy       = (r_state != IDLE) || (|r_vchain);

endmodule

// File: tb/tb_mac_operand_feeder.sv
// tb/tb_mac_operand_feeder.sv - directed vector bench for mac_operand_feeder
// Follows MAC_FEEDER_DRAIN_GAP_EN when the bench is built with it defined.
`timescale 1ns/1ps
module tb_mac_operand_feeder;
  import mac_operand_feeder_pkg::*;

  localparam int SZI = 2, SZJ = 4, DEPTH = 2, AW = 8, KW = 16;
  localparam int DW = SZJ * DEPTH * AW;
  localparam int TW = SZI * DW;
`ifdef MAC_FEEDER_DRAIN_GAP_EN
  localparam bit GAP = 1'b1;
`else
  localparam bit GAP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [TW-1:0] in_data;
  logic          in_valid, in_last;
  logic          o_ready, o_group_done, o_busy;
  logic [TW-1:0] o_amat;
  logic [2:0]    o_amatinfo;
  logic [KW-1:0] o_beat_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mac_operand_feeder #(
    .SZI(SZI), .SZJ(SZJ), .DEPTH(DEPTH), .AW(AW), .KW(KW)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_data       (in_data),
    .i_valid      (in_valid),
    .i_last       (in_last),
    .o_ready      (o_ready),
    .o_amat       (o_amat),
    .o_amatinfo   (o_amatinfo),
    .o_group_done (o_group_done),
    .o_beat_count (o_beat_count),
    .o_busy       (o_busy)
  );

  typedef struct {
    logic          valid;
    logic          last;
    elem_t         val;
    logic          ready;
    logic [TW-1:0] amat;
    logic [2:0]    info;
    logic          gd;
    logic [KW-1:0] bc;
    logic          busy;
  } vec_t;

  vec_t tbl[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [TW-1:0] got, input logic [TW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [TW-1:0] cols(input elem_t v3, input elem_t v2, input elem_t v1, input elem_t v0);
    logic [TW-1:0] r;
    elem_t         v[SZJ];
    v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
    r = '0;
    for (int i = 0; i < SZI; i++)
      for (int j = 0; j < SZJ; j++)
        for (int d = 0; d < DEPTH; d++)
          r[i*DW + (j*DEPTH + d)*AW +: AW] = v[j];
    return r;
  endfunction

  function automatic vec_t mk(input logic valid, input logic last, input elem_t val, input logic ready,
                              input logic [TW-1:0] amat, input logic [2:0] info, input logic gd,
                              input logic [KW-1:0] bc, input logic busy);
    vec_t t;
    t.valid = valid; t.last = last; t.val = val; t.ready = ready; t.amat = amat;
    t.info = info; t.gd = gd; t.bc = bc; t.busy = busy;
    return t;
  endfunction

  task automatic chk_all(input string tag, input logic ready, input logic [TW-1:0] amat,
                         input logic [2:0] info, input logic gd, input logic [KW-1:0] bc, input logic busy);
    chk({tag, ".ready"}, TW'(o_ready), TW'(ready));
    chk({tag, ".amat"}, o_amat, amat);
    chk({tag, ".info"}, TW'(o_amatinfo), TW'(info));
    chk({tag, ".group_done"}, TW'(o_group_done), TW'(gd));
    chk({tag, ".beat_count"}, TW'(o_beat_count), TW'(bc));
    chk({tag, ".busy"}, TW'(o_busy), TW'(busy));
  endtask

  int          acc_cyc[3];
  int          idx, low, gd_total;
  logic [2:0]  info_at[24];
  logic        gd_at[24];
  logic        rdy_at[24];

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    repeat (3) tick();
    chk_all("reset", 1'b1, '0, 3'b000, 1'b0, '0, 1'b0);
    rst = 1'b0;

    for (int k = 0; k < 10; k++) tbl.push_back(mk(0, 0, 8'h00, 1, '0, 3'b000, 0, 0, 0));
    // single beat with last: column 3 first, column 0 four cycles after accept
    tbl.push_back(mk(1, 1, 8'h11, ~GAP, cols(8'h11, 0, 0, 0), 3'b111, 0, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, ~GAP, cols(0, 8'h11, 0, 0), 3'b000, 0, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, ~GAP, cols(0, 0, 8'h11, 0), 3'b000, 0, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1,    cols(0, 0, 0, 8'h11), 3'b000, 1, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1,    '0,                   3'b000, 0, 0, 0));
    // three-beat group 1,2,3
    tbl.push_back(mk(1, 0, 8'h01, 1,    cols(1, 0, 0, 0), 3'b110, 0, 1, 1));
    tbl.push_back(mk(1, 0, 8'h02, 1,    cols(2, 1, 0, 0), 3'b100, 0, 2, 1));
    tbl.push_back(mk(1, 1, 8'h03, ~GAP, cols(3, 2, 1, 0), 3'b101, 0, 3, 1));
    tbl.push_back(mk(0, 0, 8'h00, ~GAP, cols(0, 3, 2, 1), 3'b000, 0, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, ~GAP, cols(0, 0, 3, 2), 3'b000, 0, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1,    cols(0, 0, 0, 3), 3'b000, 1, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1,    '0,               3'b000, 0, 0, 0));

    for (int k = 0; k < tbl.size(); k++) begin
      in_valid = tbl[k].valid;
      in_last  = tbl[k].last;
      in_data  = {(TW/AW){tbl[k].val}};
      tick();
      chk_all($sformatf("v%0d", k), tbl[k].ready, tbl[k].amat, tbl[k].info, tbl[k].gd, tbl[k].bc, tbl[k].busy);
    end

    // two groups offered back to back: {4,5 last} then {6 last}
    idx = 0;
    for (int n = 0; n < 24; n++) begin
      rdy_at[n]  = o_ready;
      gd_at[n]   = o_group_done;
      info_at[n] = o_amatinfo;
      if (idx < 3) begin
        in_valid = 1'b1;
        in_last  = (idx != 0);
        in_data  = {(TW/AW){8'(4 + idx)}};
      end else begin
        in_valid = 1'b0; in_last = 1'b0; in_data = '0;
      end
      if (in_valid && o_ready) begin
        acc_cyc[idx] = n;
        idx++;
      end
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    chk("b2b.accepted", TW'(idx), TW'(3));
    if (idx == 3) begin
      chk("b2b.in_group_spacing", TW'(acc_cyc[1] - acc_cyc[0]), TW'(1));
      chk("b2b.group_spacing", TW'(acc_cyc[2] - acc_cyc[1]), GAP ? TW'(4) : TW'(1));
      low = 0;
      for (int n = acc_cyc[1] + 1; n < acc_cyc[2]; n++) if (!rdy_at[n]) low++;
      chk("b2b.ready_low_cycles", TW'(low), GAP ? TW'(3) : TW'(0));
      chk("b2b.second_first_info", TW'(info_at[acc_cyc[2] + 1]), TW'(3'b111));
      chk("b2b.gd_group1", TW'(gd_at[acc_cyc[1] + 4]), TW'(1));
      chk("b2b.gd_group2", TW'(gd_at[acc_cyc[2] + 4]), TW'(1));
      gd_total = 0;
      for (int n = 0; n < 24; n++) if (gd_at[n]) gd_total++;
      chk("b2b.gd_total", TW'(gd_total), TW'(2));
    end

    // reset two cycles after accepting a one-beat group
    in_valid = 1'b1; in_last = 1'b1; in_data = {(TW/AW){8'h77}};
    tick();
    in_valid = 1'b0; in_last = 1'b0; in_data = '0;
    tick();
    chk("rst_mid.busy_before", TW'(o_busy), TW'(1));
    chk("rst_mid.amat_before", o_amat, cols(0, 8'h77, 0, 0));
    rst = 1'b1;
    tick();
    chk_all("rst_mid", 1'b1, '0, 3'b000, 1'b0, '0, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_all($sformatf("rst_after%0d", k), 1'b1, '0, 3'b000, 1'b0, '0, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_operand_feeder.md
# mac_operand_feeder

Operand feeder on the input side of the MAC array. It accepts one un-skewed row-slice of A operands per beat over a valid/ready handshake. It delays each PE column group by its position in the accumulation chain, so the chain-tail column (J=SZJ-1) fires first and column 0 fires last. Its outputs are the skewed A vectors plus the matching Info word for the array's amat/amatinfo inputs. Idle cycles are filled with zero bubbles, because the array never stalls.

## Interface
Parameters:
- SZI, 4, rows of the array (I dimension)
- SZJ, 4, PE column groups along the chain (J dimension), ≥2
- DEPTH, 4, elements per PE input (PE_INPUT_DEPTH)
- AW, 8, element width in bits
- KW, 16, width of the beat counter
- DW = SZJ*DEPTH*AW, derived; width of one row of the slice

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_data  in  SZI×DW  row-slice; element (i, J*DEPTH+d) at bits [(J*DEPTH+d)*AW +: AW] of row i
- in_valid  in  1  slice valid
- in_last  in  1  final k-step of the current accumulation group
- in_ready  out  1  feeder accepts this cycle
- amat  out  SZI×DW  skewed operands to the MAC array
- amatinfo  out  Info  {valid, first, last} aligned to column SZJ-1
- group_done  out  1  one-cycle pulse when column 0 has emitted the last beat of a group
- beat_count  out  KW  beats accepted in the current group
- busy  out  1  state != IDLE, or any skew stage holds valid data

## Operation
- A beat is accepted when in_valid && in_ready.
- Stage 0 captures the whole slice and the per-column valid bits. Column group J passes through SZJ-1-J further register stages before it reaches amat.
- On a cycle with no accepted beat, stage 0 loads all-zero data with valid=0. A bubble therefore contributes 0 to every chain sum.
- amatinfo is taken from stage 0, so it is aligned with column SZJ-1:
  - valid: a beat was accepted.
  - first: the beat is the first of its group.
  - last: in_last was set on the beat.
- State machine:
  - IDLE → RUN on the first accepted beat; first=1 on that beat and beat_count=1.
  - RUN: beat_count increments on each accept and saturates at 2^KW-1. An accepted beat with in_last goes to DRAIN, or straight back to IDLE when the macro below is absent.
  - DRAIN: in_ready=0 for SZJ-1 cycles, counted by drain_cnt, then IDLE.
- beat_count clears to 0 on the cycle after the last beat is accepted.
- group_done pulses SZJ cycles after the accept of a beat with last=1, when that beat's column 0 data appears on amat. The pulse is tracked by a last-flag shift chain, so groups can overlap.
- Simultaneous events:
  - last accepted in IDLE, a one-beat group: first=last=1; next state DRAIN (or IDLE).
  - group_done and a new first beat in the same cycle are legal, and both are reported.
- Reset mid-operation: all skew stages, valid bits and the last chain clear to 0 and the state returns to IDLE. In-flight beats are discarded and no group_done is issued for them.

## Timing
- Reset values: amat=0, amatinfo=0, group_done=0, beat_count=0, busy=0.
- in_ready=1 after reset.
- Column J of a beat accepted in cycle t appears on amat in cycle t+1+(SZJ-1-J). amatinfo appears in cycle t+1.
- in_ready is a function of state only; it has no combinational path from in_valid.
- Throughput: 1 beat/cycle inside a group. With the macro enabled, a gap of SZJ-1 cycles follows each group.

## Configuration
- MAC_FEEDER_DRAIN_GAP_EN
  - Defined: the DRAIN state exists and in_ready stays low for SZJ-1 cycles after each last beat. Consecutive groups never share the chain.
  - Undefined: there is no DRAIN state. Groups run back to back and in_ready is constant 1 outside reset.

## Structure
- Shared package:
  - Info typedef {valid, first, last}
  - state enum {IDLE, RUN, DRAIN}
  - element typedef logic [AW-1:0]
- Sub-module skew_delay: a parameterised N-stage register line with synchronous reset, where N=0 is a wire. It is instantiated once per column group with N=SZJ-1-J.

## Test plan
All scenarios use SZI=2, SZJ=4, DEPTH=2, AW=8.
- Reset, then idle for 10 cycles → amat=0, amatinfo.valid=0, in_ready=1, busy=0 throughout.
- Single beat, every element = 8'h11, in_last=1, accepted at t=5:
  - amatinfo={1,1,1} at t=6.
  - Column 3 nonzero at t=6, column 2 at t=7, column 1 at t=8, column 0 at t=9.
  - group_done=1 at t=9.
- Three-beat group with values 1, 2, 3 back to back → beat_count=1, 2, 3, then 0. Column 0 emits 1, 2, 3 at t+4..t+6. Columns are zero elsewhere.
- Macro on, two groups offered back to back → in_ready=0 for exactly 3 cycles after the first last beat. The second first beat reaches stage 0 no earlier than 4 cycles after the first last beat.
- Macro off, same stimulus → no gap, and group_done pulses on two consecutive group ends.
- reset asserted 2 cycles after a beat is accepted → all outputs 0 on the next cycle, no group_done, and state IDLE.
